// File: rtl/mux4_rr_collect.sv
// mux4_rr_collect: gathers four valid/ready channels into one registered output tagged with the source index.
// Latency: 1 cycle from input transfer to out_valid; full throughput, no bubble when switching channels.
// Backpressure: in_ready is zero on all channels while the output register is full and out_ready is low.
// Build option: define MUX4_FIXED_PRIO_EN for fixed priority (channel 0 highest); default is round-robin
// with a burst hold of up to BURST consecutive grants to the current owner.
module mux4_rr_collect #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    output logic [3:0]      in_ready,
    input  logic [4*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_sel
);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_sel_q, out_sel_d;

    logic       load;
    logic [3:0] grant;
    logic [1:0] gidx;
    logic       fire;

    // Output register can accept a new word when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

`ifdef MUX4_FIXED_PRIO_EN

    // Fixed priority: lowest-numbered valid channel wins.
    always_comb begin
        grant = 4'b0000;
        gidx  = 2'd0;
        if (in_valid[0]) begin
            grant = 4'b0001;
            gidx  = 2'd0;
        end else if (in_valid[1]) begin
            grant = 4'b0010;
            gidx  = 2'd1;
        end else if (in_valid[2]) begin
            grant = 4'b0100;
            gidx  = 2'd2;
        end else if (in_valid[3]) begin
            grant = 4'b1000;
            gidx  = 2'd3;
        end
    end

`else

    localparam int CW = $clog2(BURST + 1);

    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold;
    logic          found;
    logic [1:0]    cand;

    // Round-robin arbitration: keep the owner while its burst lasts, else search from owner+1.
    always_comb begin
        grant = 4'b0000;
        gidx  = owner_q;
        found = 1'b0;
        cand  = owner_q;
        hold  = (cnt_q != '0) && in_valid[owner_q] && (cnt_q < CW'(BURST));
        if (hold) begin
            grant[owner_q] = 1'b1;
            gidx           = owner_q;
        end else begin
            // k=4 wraps back to the owner itself, giving it the last look.
            for (int k = 1; k <= 4; k++) begin
                cand = owner_q + 2'(k);
                if (!found && in_valid[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    gidx        = cand;
                end
            end
        end
    end

    // Burst bookkeeping: count repeat grants to the owner (saturating), restart at 1 on a new owner.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (fire) begin
            if (gidx == owner_q) begin
                if (cnt_q < CW'(BURST)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                owner_d = gidx;
                cnt_d   = CW'(1);
            end
        end
    end

    // Owner/count state; owner resets to 3 so the first search order is 0,1,2,3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 2'd3;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

`endif

    assign fire     = load && (|grant);
    assign in_ready = load ? grant : 4'b0000;

    // Output next-state: load on transfer, empty on drain, otherwise hold stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[gidx*DW +: DW];
            out_sel_d   = gidx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers; reset discards any in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_collect.sv
// Directed bench for mux4_rr_collect: two instances (BURST=4 and BURST=1) share stimulus.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_mux4_rr_collect;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  rdy4, rdy1;
    logic        ov4, ov1;
    logic [7:0]  od4, od1;
    logic [1:0]  os4, os1;

    int chk_cnt;
    int pass_cnt;

    mux4_rr_collect #(.DW(8), .BURST(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_sel(os4)
    );

    mux4_rr_collect #(.DW(8), .BURST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sel(os1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    task automatic set_data(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        in_data = {b3, b2, b1, b0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1; in_data = '0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (ov4 !== 1'b0) $display("FAIL reset_valid got %0b want 0", ov4); else pass_cnt++;
        chk_cnt++; if (od4 !== 8'h00) $display("FAIL reset_data got %h want 00", od4); else pass_cnt++;
        chk_cnt++; if (os4 !== 2'd0) $display("FAIL reset_sel got %0d want 0", os4); else pass_cnt++;
        rst = 1'b0;
        in_valid = 4'b0100; set_data(8'h00, 8'h00, 8'h33, 8'h00);
        @(negedge clk);
        chk_cnt++; if (ov4 !== 1'b1 || od4 !== 8'h33) $display("FAIL pre_reset_load got %0b/%h want 1/33", ov4, od4); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (ov4 !== 1'b0) $display("FAIL async_reset_valid got %0b want 0", ov4); else pass_cnt++;
        chk_cnt++; if (od4 !== 8'h00) $display("FAIL async_reset_data got %h want 00", od4); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b1111; set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        chk_cnt++; if (rdy4 !== 4'b0001) $display("FAIL first_grant_ready got %b want 0001", rdy4); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (os4 !== 2'd0 || od4 !== 8'hA0) $display("FAIL first_grant_out got %0d/%h want 0/a0", os4, od4); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] e4, e1;
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b1; set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        for (int i = 0; i < 12; i++) begin
            e4 = 2'((i / 4) % 4);
            e1 = 2'(i % 4);
            @(negedge clk);
            chk_cnt++; if (ov4 !== 1'b1 || os4 !== e4 || od4 !== (8'hA0 + 8'(e4)))
                $display("FAIL burst4_seq[%0d] got %0b/%0d/%h want 1/%0d/%h", i, ov4, os4, od4, e4, 8'hA0 + 8'(e4));
            else pass_cnt++;
            chk_cnt++; if (ov1 !== 1'b1 || os1 !== e1 || od1 !== (8'hA0 + 8'(e1)))
                $display("FAIL burst1_seq[%0d] got %0b/%0d/%h want 1/%0d/%h", i, ov1, os1, od1, e1, 8'hA0 + 8'(e1));
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 4'b0100; out_ready = 1'b1; set_data(8'h00, 8'h00, 8'h5A, 8'h00);
        @(negedge clk);
        chk_cnt++; if (ov4 !== 1'b1 || os4 !== 2'd2 || od4 !== 8'h5A) $display("FAIL stall_setup got %0b/%0d/%h want 1/2/5a", ov4, os4, od4); else pass_cnt++;
        out_ready = 1'b0; in_valid = 4'b1111; set_data(8'h11, 8'h22, 8'h77, 8'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++; if (rdy4 !== 4'b0000) $display("FAIL stall_ready[%0d] got %b want 0000", i, rdy4); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (ov4 !== 1'b1 || os4 !== 2'd2 || od4 !== 8'h5A)
                $display("FAIL stall_hold[%0d] got %0b/%0d/%h want 1/2/5a", i, ov4, os4, od4);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (rdy4 !== 4'b0100) $display("FAIL unstall_ready got %b want 0100", rdy4); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (ov4 !== 1'b1 || os4 !== 2'd2 || od4 !== 8'h77) $display("FAIL unstall_out got %0b/%0d/%h want 1/2/77", ov4, os4, od4); else pass_cnt++;
    endtask

    task automatic test_single_channel();
        logic [7:0] d;
        do_reset();
        in_valid = 4'b0100; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'h20 + 8'(i);
            set_data(8'hE0, 8'hE1, d, 8'hE3);
            #1;
            chk_cnt++; if (rdy4 !== 4'b0100) $display("FAIL ch2_ready[%0d] got %b want 0100", i, rdy4); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (ov4 !== 1'b1 || os4 !== 2'd2 || od4 !== d)
                $display("FAIL ch2_out[%0d] got %0b/%0d/%h want 1/2/%h", i, ov4, os4, od4, d);
            else pass_cnt++;
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk_cnt++; if (ov4 !== 1'b0 || os4 !== 2'd2 || od4 !== 8'h25) $display("FAIL drain got %0b/%0d/%h want 0/2/25", ov4, os4, od4); else pass_cnt++;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        in_valid = 4'b1111; out_ready = 1'b1; set_data(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++; if (ov4 !== 1'b1 || os4 !== 2'd0 || od4 !== 8'hB0)
                $display("FAIL fixed_all[%0d] got %0b/%0d/%h want 1/0/b0", i, ov4, os4, od4);
            else pass_cnt++;
        end
        in_valid = 4'b1110;
        #1;
        chk_cnt++; if (rdy4 !== 4'b0010) $display("FAIL fixed_ready got %b want 0010", rdy4); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (os4 !== 2'd1 || od4 !== 8'hB1) $display("FAIL fixed_drop0 got %0d/%h want 1/b1", os4, od4); else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        rst = 1'b1; in_valid = 4'b0000; in_data = '0; out_ready = 1'b1;
        test_reset();
`ifdef MUX4_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_stall();
        test_single_channel();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
